free_list_ctrl: RTL and testbench
=================================

FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

Interface
REQ-001 SHALL have parameter NUM_PHYS, default 64: physical registers in the PHYS_REG file.
REQ-002 SHALL have parameter NUM_ARCH, default 32: architectural registers, always committed-mapped.
REQ-003 SHALL have ports, one per line:
  CLK  in  1  single clock, all state on rising edge
  RESET  in  1  synchronous, active-high reset
  FLUSH  in  1  squash all speculative allocations
  alloc_req  in  1  rename requests one physical tag
  alloc_grant  out  1  tag on alloc_reg is taken this cycle
  alloc_reg  out  6  physical tag offered to rename
  commit_valid  in  1  oldest speculative allocation retired
  release_valid  in  1  retire frees a stale physical tag
  release_reg  in  6  tag being freed (old RRAT mapping)
  free_count  out  7  tags available for allocation
  halt_rename  out  1  no tag available; rename stalls
  protocol_err  out  1  registered one-cycle pulse on illegal commit/release

Function
REQ-004 SHALL hold a circular list of FL_DEPTH = NUM_PHYS-NUM_ARCH (32) 6-bit tags, with pointers spec_head, commit_head, tail, each log2(FL_DEPTH) bits plus a wrap bit.
REQ-005 SHALL compute free_count = tail - spec_head (modulo 2*FL_DEPTH), range 0..32.
REQ-006 SHALL drive alloc_reg combinationally as list[spec_head]; value is undefined-but-stable when free_count==0.
REQ-007 SHALL assert alloc_grant = alloc_req & (free_count!=0) & !FLUSH, same cycle, zero latency.
REQ-008 SHALL advance spec_head by 1 on the edge following a granted cycle.
REQ-009 SHALL assert halt_rename = (free_count==0), combinationally.
REQ-010 SHALL, on release_valid, write release_reg at list[tail] and advance tail by 1.
REQ-011 SHALL not bypass: a release in the cycle free_count==0 does not grant an alloc in that cycle; the tag is available next cycle.
REQ-012 SHALL, on commit_valid, advance commit_head by 1.
REQ-013 SHALL ignore commit_valid when commit_head==spec_head, and pulse protocol_err next cycle.
REQ-014 SHALL ignore release_valid when tail-commit_head==FL_DEPTH (list full), and pulse protocol_err next cycle.
REQ-015 SHALL, on FLUSH, set spec_head to the commit_head value after applying any same-cycle commit_valid.
REQ-016 SHALL accept a same-cycle release_valid during FLUSH normally.
REQ-017 SHALL process alloc, commit, release in the same cycle independently; free_count next = free_count - grant + release.
REQ-018 SHALL never let spec_head pass tail, nor commit_head pass spec_head.

Reset
REQ-019 SHALL, while RESET high at an edge, load list[i] = NUM_ARCH+i for i=0..31.
REQ-020 SHALL reset spec_head=commit_head=0, tail=wrap-set 0 (full), free_count=32.
REQ-021 SHALL reset alloc_reg=32, alloc_grant=0, halt_rename=0, protocol_err=0.
REQ-022 SHALL give RESET priority over FLUSH, alloc, commit, release; mid-operation reset discards all pending allocations.

Structure
REQ-023 SHALL take NUM_PHYS, NUM_ARCH, PTAG_W (6), FL_DEPTH from the shared rename package also used by TABLE_obj and PHYS_REG.
REQ-024 SHALL place tag storage in one sub-module free_list_ram: FL_DEPTH x PTAG_W, one synchronous write, one asynchronous read.
REQ-025 SHALL keep pointer/count/flush logic in free_list_ctrl.

Verification
REQ-026 Reset, then alloc_req held 33 cycles -> grants tags 32..63 in order, free_count 32->0, 33rd cycle alloc_grant=0, halt_rename=1.
REQ-027 Drain to 0, release_reg=5 with alloc_req high -> no grant that cycle; next cycle alloc_grant=1, alloc_reg=5, free_count=0 after.
REQ-028 Alloc 4 (32..35), commit 2, FLUSH -> free_count 30; next two grants return 34, 35.
REQ-029 FLUSH with same-cycle commit_valid after 3 allocs, 1 prior commit -> spec_head=commit_head=2; next grant returns 34.
REQ-030 commit_valid with no outstanding alloc after reset -> protocol_err pulses 1 cycle, pointers unchanged; release_valid at full -> same.
REQ-031 Random alloc/commit/release/flush 10k cycles vs scoreboard -> no duplicate live tag, free+spec+committed = NUM_PHYS, free_count always matches.

Source files
------------

// File: rtl/free_list_ctrl_pkg.sv
// Shared rename package: register-file sizing, free-list pointer types and
// small pointer helpers used by the rename table, PHYS_REG and the free list.
package free_list_ctrl_pkg;

    // Register-file sizing shared across the rename slice.
    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int PTAG_W   = $clog2(NUM_PHYS);

    // The free list only ever holds the physical tags not pinned by the
    // committed architectural mapping.
    localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int FL_IDX_W = $clog2(FL_DEPTH);
    localparam int FL_PTR_W = FL_IDX_W + 1;
    localparam int FL_CNT_W = FL_PTR_W + 1;

    typedef logic [PTAG_W-1:0]   ptag_t;
    typedef logic [FL_IDX_W-1:0] fl_idx_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_CNT_W-1:0] fl_cnt_t;

    // Tail starts one full lap ahead of the heads: index 0 with the wrap bit
    // set means every slot holds a free tag.
    localparam fl_ptr_t FL_TAIL_RESET = {1'b1, {FL_IDX_W{1'b0}}};

    // Reason the last cycle was flagged as a protocol violation; both
    // violations can happen in the same cycle.
    typedef enum logic [1:0] {
        FL_ERR_NONE    = 2'b00,
        FL_ERR_COMMIT  = 2'b01,
        FL_ERR_RELEASE = 2'b10,
        FL_ERR_BOTH    = 2'b11
    } fl_err_e;

    // Advance a wrap-bit pointer by one slot.
    function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t p);
        return p + fl_ptr_t'(1);
    endfunction

    // Number of slots from lo up to hi; the wrap bit makes a full lap
    // distinguishable from an empty span.
    function automatic fl_cnt_t fl_span(input fl_ptr_t hi, input fl_ptr_t lo);
        fl_ptr_t diff;
        diff = hi - lo;
        return {1'b0, diff};
    endfunction

    // Storage slot addressed by a pointer.
    function automatic fl_idx_t fl_slot(input fl_ptr_t p);
        return p[FL_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/free_list_ram.sv
// Circular tag storage for the free list: one synchronous write port for
// released tags, one asynchronous read port feeding the rename stage.
module free_list_ram
    import free_list_ctrl_pkg::*;
#(
    parameter int DEPTH    = FL_DEPTH,
    parameter int BASE_TAG = NUM_ARCH
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                wr_en,
    input  logic [FL_IDX_W-1:0] wr_idx,
    input  logic [PTAG_W-1:0]   wr_tag,
    input  logic [FL_IDX_W-1:0] rd_idx,
    output logic [PTAG_W-1:0]   rd_tag
);

    ptag_t mem [DEPTH];

    // Reset fills the list with every non-architectural tag in ascending
    // order; afterwards only released tags are written back at the tail.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PTAG_W'(BASE_TAG + i);
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_tag;
        end
    end

    assign rd_tag = mem[rd_idx];

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list for rename. Three pointers walk one circular
// list: spec_head hands out tags, commit_head trails it as allocations
// retire, and tail appends tags freed at retirement. A flush rewinds
// spec_head to commit_head, returning all speculative tags in their
// original order.
module free_list_ctrl
    import free_list_ctrl_pkg::*;
#(
    parameter int NUM_PHYS = free_list_ctrl_pkg::NUM_PHYS,
    parameter int NUM_ARCH = free_list_ctrl_pkg::NUM_ARCH
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FLUSH,
    input  logic                alloc_req,
    output logic                alloc_grant,
    output logic [PTAG_W-1:0]   alloc_reg,
    input  logic                commit_valid,
    input  logic                release_valid,
    input  logic [PTAG_W-1:0]   release_reg,
    output logic [FL_CNT_W-1:0] free_count,
    output logic                halt_rename,
    output logic                protocol_err
);

    localparam int DEPTH = NUM_PHYS - NUM_ARCH;
    localparam fl_cnt_t DEPTH_CNT = fl_cnt_t'(DEPTH);

    fl_ptr_t spec_head_q;
    fl_ptr_t commit_head_q;
    fl_ptr_t tail_q;
    fl_ptr_t spec_head_d;
    fl_ptr_t commit_head_d;
    fl_ptr_t tail_d;

    fl_err_e err_cause_q;
    fl_err_e err_cause_d;

    logic    list_empty;
    logic    list_full;
    logic    commit_bad;
    logic    commit_ok;
    logic    release_bad;
    logic    release_ok;
    ptag_t   head_tag;

    // Tags available to rename are those between spec_head and tail.
    assign free_count  = fl_span(tail_q, spec_head_q);
    assign list_empty  = (free_count == '0);
    assign halt_rename = list_empty;

    // Every slot between commit_head and tail holds a tag still owned by the
    // list (free or speculatively handed out); a release with no slot left
    // would overwrite one of them.
    assign list_full   = (fl_span(tail_q, commit_head_q) == DEPTH_CNT);

    // A commit with nothing outstanding, or a release into a full list, is a
    // retire-side bug; the request is dropped so the pointers stay coherent.
    assign commit_bad  = commit_valid & (commit_head_q == spec_head_q);
    assign commit_ok   = commit_valid & ~commit_bad;
    assign release_bad = release_valid & list_full;
    assign release_ok  = release_valid & ~release_bad;

    // Grant depends only on registered occupancy, so a tag released this
    // cycle cannot be handed out until the next one.
    assign alloc_grant = alloc_req & ~list_empty & ~FLUSH & ~RESET;
    assign alloc_reg   = head_tag;

    assign protocol_err = (err_cause_q != FL_ERR_NONE);

    free_list_ram #(
        .DEPTH    (DEPTH),
        .BASE_TAG (NUM_ARCH)
    ) u_ram (
        .CLK    (CLK),
        .RESET  (RESET),
        .wr_en  (release_ok),
        .wr_idx (fl_slot(tail_q)),
        .wr_tag (release_reg),
        .rd_idx (fl_slot(spec_head_q)),
        .rd_tag (head_tag)
    );

    // Next pointer values; the flush target includes this cycle's commit so
    // an instruction retiring alongside the squash is not rolled back.
    always_comb begin
        commit_head_d = commit_head_q;
        spec_head_d   = spec_head_q;
        tail_d        = tail_q;

        if (commit_ok) begin
            commit_head_d = fl_ptr_inc(commit_head_q);
        end

        if (FLUSH) begin
            spec_head_d = commit_head_d;
        end else if (alloc_grant) begin
            spec_head_d = fl_ptr_inc(spec_head_q);
        end

        if (release_ok) begin
            tail_d = fl_ptr_inc(tail_q);
        end
    end

    // Record which retire-side rule was broken so the error flag is a clean
    // registered pulse.
    always_comb begin
        err_cause_d = FL_ERR_NONE;
        unique case ({release_bad, commit_bad})
            2'b01:   err_cause_d = FL_ERR_COMMIT;
            2'b10:   err_cause_d = FL_ERR_RELEASE;
            2'b11:   err_cause_d = FL_ERR_BOTH;
            default: err_cause_d = FL_ERR_NONE;
        endcase
    end

    // Pointer and error state; reset discards every outstanding allocation
    // and leaves the list full.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= FL_TAIL_RESET;
            err_cause_q   <= FL_ERR_NONE;
        end else begin
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            err_cause_q   <= err_cause_d;
        end
    end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Self-checking bench for free_list_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a queue-level model of the
// rename tag lifecycle (free -> speculative -> architectural -> stale -> free).
module tb_free_list_ctrl;

    logic       CLK;
    logic       RESET;
    logic       FLUSH;
    logic       alloc_req;
    logic       alloc_grant;
    logic [5:0] alloc_reg;
    logic       commit_valid;
    logic       release_valid;
    logic [5:0] release_reg;
    logic [6:0] free_count;
    logic       halt_rename;
    logic       protocol_err;

    int assertCount = 0;
    int failCount   = 0;

    bit checkEnable = 0;
    bit invEnable   = 0;

    // Reference model: tags waiting to be handed out (in hand-out order),
    // tags handed out but not retired, the committed architectural mapping,
    // and displaced tags waiting to be released.
    int freeQ[$];
    int specQ[$];
    int staleQ[$];
    int archMap[32];
    bit expErr;

    free_list_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .FLUSH         (FLUSH),
        .alloc_req     (alloc_req),
        .alloc_grant   (alloc_grant),
        .alloc_reg     (alloc_reg),
        .commit_valid  (commit_valid),
        .release_valid (release_valid),
        .release_reg   (release_reg),
        .free_count    (free_count),
        .halt_rename   (halt_rename),
        .protocol_err  (protocol_err)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        freeQ.delete();
        specQ.delete();
        staleQ.delete();
        for (int i = 0; i < 32; i++) begin
            freeQ.push_back(32 + i);
            archMap[i] = i;
        end
        expErr = 0;
    endtask

    // Apply one clock edge's worth of the tag-lifecycle rules.
    task automatic modelStep();
        bit grant;
        bit commitOk;
        bit releaseOk;
        int tag;
        int slot;
        if (RESET) begin
            modelReset();
            return;
        end
        grant     = alloc_req && (freeQ.size() > 0) && !FLUSH;
        commitOk  = commit_valid && (specQ.size() > 0);
        releaseOk = release_valid && ((freeQ.size() + specQ.size()) < 32);
        expErr    = (commit_valid && !commitOk) || (release_valid && !releaseOk);
        if (grant) begin
            tag = freeQ.pop_front();
            specQ.push_back(tag);
        end
        if (commitOk) begin
            tag  = specQ.pop_front();
            slot = $urandom_range(31);
            staleQ.push_back(archMap[slot]);
            archMap[slot] = tag;
        end
        if (releaseOk) begin
            freeQ.push_back(int'(release_reg));
            if (staleQ.size() > 0 && staleQ[0] == int'(release_reg)) begin
                void'(staleQ.pop_front());
            end
        end
        if (FLUSH) begin
            freeQ = {specQ, freeQ};
            specQ.delete();
        end
    endtask

    task automatic checkInvariants();
        bit seen[64];
        int dups;
        dups = 0;
        foreach (seen[i]) seen[i] = 0;
        foreach (freeQ[i])   begin if (seen[freeQ[i]])   dups++; seen[freeQ[i]]   = 1; end
        foreach (specQ[i])   begin if (seen[specQ[i]])   dups++; seen[specQ[i]]   = 1; end
        foreach (staleQ[i])  begin if (seen[staleQ[i]])  dups++; seen[staleQ[i]]  = 1; end
        foreach (archMap[i]) begin if (seen[archMap[i]]) dups++; seen[archMap[i]] = 1; end
        checkOutput("duplicate_live_tags", dups, 0);
        checkOutput("tag_conservation", freeQ.size() + specQ.size() + staleQ.size() + 32, 64);
    endtask

    // Compare the DUT against the model on every non-reset cycle.
    always @(negedge CLK) begin
        if (checkEnable && !RESET) begin
            checkOutput("free_count", int'(free_count), freeQ.size());
            checkOutput("halt_rename", int'(halt_rename), int'(freeQ.size() == 0));
            checkOutput("alloc_grant", int'(alloc_grant),
                        int'(alloc_req && (freeQ.size() > 0) && !FLUSH));
            checkOutput("protocol_err", int'(protocol_err), int'(expErr));
            if (freeQ.size() > 0) begin
                checkOutput("alloc_reg", int'(alloc_reg), freeQ[0]);
            end
            if (invEnable) checkInvariants();
        end
    end

    task automatic applyStimulus(input bit a, input bit c, input bit r,
                                 input logic [5:0] rt, input bit f);
        alloc_req     = a;
        commit_valid  = c;
        release_valid = r;
        release_reg   = rt;
        FLUSH         = f;
        @(negedge CLK);
        #1;
    endtask

    task automatic endCycle();
        @(posedge CLK);
        modelStep();
        #1;
    endtask

    task automatic applyReset();
        RESET = 1;
        applyStimulus(0, 0, 0, 6'd0, 0);
        endCycle();
        RESET = 0;
        checkEnable = 1;
    endtask

    initial begin
        bit a, c, r, f;
        logic [5:0] rt;

        RESET = 1;
        FLUSH = 0;
        alloc_req = 0;
        commit_valid = 0;
        release_valid = 0;
        release_reg = 0;
        modelReset();

        // Reset state.
        applyReset();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("reset_free_count", int'(free_count), 32);
        checkOutput("reset_alloc_reg", int'(alloc_reg), 32);
        checkOutput("reset_halt", int'(halt_rename), 0);
        checkOutput("reset_grant", int'(alloc_grant), 0);
        checkOutput("reset_err", int'(protocol_err), 0);
        endCycle();

        // Drain: tags 32..63 in order, then stall.
        for (int k = 0; k <= 32; k++) begin
            applyStimulus(1, 0, 0, 6'd0, 0);
            if (k < 32) begin
                checkOutput("drain_tag", int'(alloc_reg), 32 + k);
                checkOutput("drain_grant", int'(alloc_grant), 1);
                checkOutput("drain_count", int'(free_count), 32 - k);
            end else begin
                checkOutput("drained_grant", int'(alloc_grant), 0);
                checkOutput("drained_halt", int'(halt_rename), 1);
            end
            endCycle();
        end

        // Release into an empty list: no bypass, tag 5 available next cycle.
        applyStimulus(0, 1, 0, 6'd0, 0);
        endCycle();
        applyStimulus(1, 0, 1, 6'd5, 0);
        checkOutput("nobypass_grant", int'(alloc_grant), 0);
        endCycle();
        applyStimulus(1, 0, 0, 6'd0, 0);
        checkOutput("released_grant", int'(alloc_grant), 1);
        checkOutput("released_tag", int'(alloc_reg), 5);
        endCycle();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("released_count_after", int'(free_count), 0);
        endCycle();

        // Alloc 4, commit 2, flush: 34 and 35 come back first.
        applyReset();
        for (int k = 0; k < 4; k++) begin applyStimulus(1, 0, 0, 6'd0, 0); endCycle(); end
        for (int k = 0; k < 2; k++) begin applyStimulus(0, 1, 0, 6'd0, 0); endCycle(); end
        applyStimulus(0, 0, 0, 6'd0, 1);
        endCycle();
        applyStimulus(1, 0, 0, 6'd0, 0);
        checkOutput("flush_count", int'(free_count), 30);
        checkOutput("flush_tag0", int'(alloc_reg), 34);
        endCycle();
        applyStimulus(1, 0, 0, 6'd0, 0);
        checkOutput("flush_tag1", int'(alloc_reg), 35);
        endCycle();

        // Flush with a same-cycle commit keeps that commit.
        applyReset();
        for (int k = 0; k < 3; k++) begin applyStimulus(1, 0, 0, 6'd0, 0); endCycle(); end
        applyStimulus(0, 1, 0, 6'd0, 0);
        endCycle();
        applyStimulus(0, 1, 0, 6'd0, 1);
        endCycle();
        applyStimulus(1, 0, 0, 6'd0, 0);
        checkOutput("flushcommit_tag", int'(alloc_reg), 34);
        checkOutput("flushcommit_count", int'(free_count), 30);
        endCycle();

        // Illegal commit and illegal release each give a one-cycle pulse.
        applyReset();
        applyStimulus(0, 1, 0, 6'd0, 0);
        endCycle();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("badcommit_err", int'(protocol_err), 1);
        checkOutput("badcommit_count", int'(free_count), 32);
        checkOutput("badcommit_tag", int'(alloc_reg), 32);
        endCycle();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("badcommit_err_clear", int'(protocol_err), 0);
        endCycle();
        applyStimulus(0, 0, 1, 6'd7, 0);
        endCycle();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("badrelease_err", int'(protocol_err), 1);
        checkOutput("badrelease_count", int'(free_count), 32);
        checkOutput("badrelease_tag", int'(alloc_reg), 32);
        endCycle();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("badrelease_err_clear", int'(protocol_err), 0);
        endCycle();

        // Reset in the middle of allocation discards everything.
        for (int k = 0; k < 5; k++) begin applyStimulus(1, 0, 0, 6'd0, 0); endCycle(); end
        applyReset();
        applyStimulus(0, 0, 0, 6'd0, 0);
        checkOutput("midreset_count", int'(free_count), 32);
        checkOutput("midreset_tag", int'(alloc_reg), 32);
        endCycle();

        // Randomized traffic following the tag lifecycle.
        applyReset();
        invEnable = 1;
        for (int n = 0; n < 10000; n++) begin
            a  = ($urandom_range(3) != 0);
            c  = ($urandom_range(2) == 0);
            f  = ($urandom_range(39) == 0);
            r  = 0;
            rt = 6'd0;
            if (staleQ.size() > 0 && $urandom_range(1) == 1) begin
                r  = 1;
                rt = 6'(staleQ[0]);
            end else if (staleQ.size() == 0 && $urandom_range(19) == 0) begin
                r  = 1;
                rt = 6'($urandom_range(63));
            end
            applyStimulus(a, c, r, rt, f);
            endCycle();
        end
        invEnable = 0;
        checkEnable = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
